spi_regfile_target: RTL
=======================

# spi_regfile_target

SPI mode-0 target that emulates a register-mapped SPI peripheral in the style of the MCP23S17. It accepts framed opcode/address/data transactions with multi-byte sequential access, serves reads from a parametrised register file or from external read-only inputs, and publishes every register to the fabric. It sits directly on the SPI pins and replaces single-byte fixed-response SPI sinks in the SPI emulation path.

## Interface

Parameters:
- NUM_REGS, 22: number of byte registers, addresses 0..NUM_REGS-1 (2..256).
- DEV_OPCODE, 7'h20: required value of opcode bits [7:1].
- SEQ_EN, 1: 1 = address auto-increments after each data byte; 0 = address holds.
- RO_MASK, all 0 (NUM_REGS bits): bit n set = register n is read-only and sourced from ext_i.
- REG_INIT, all 0 (NUM_REGS*8 bits): reset value of register n is REG_INIT[8n+7:8n].

Ports:
- sclk_i  in  1  SPI clock. Mode 0: sample on rising edge, drive on falling edge. Sole clock.
- rst  in  1  Reset. Synchronous, active-high; acts on posedge sclk_i.
- csn_i  in  1  Chip select, active-low. High asynchronously aborts the frame.
- mosi_i  in  1  Serial data in, MSB first.
- miso_o  out  1  Serial data out, MSB first.
- miso_oe_o  out  1  High while a read-data byte is being shifted out.
- ext_i  in  NUM_REGS*8  Read-only register sources, byte n at [8n+7:8n].
- regs_o  out  NUM_REGS*8  Current register file contents.
- wr_stb_o  out  1  One-sclk pulse per committed write.
- wr_addr_o  out  8  Address of the committed write.
- wr_data_o  out  8  Data of the committed write.

## Operation

- Frame = csn_i low period. Byte 0 = opcode: [7:1] device ID, [0] R/W (0 = write, 1 = read). Byte 1 = register address. Bytes 2+ = data.
- States: OPCODE, ADDR, WDATA, RDATA, IGNORE. A 3-bit bit counter runs 7..0 and wraps 0 -> 7 on each rising edge.
- OPCODE: shifts in 8 bits. At bit 0: if [7:1] == DEV_OPCODE, go to ADDR; otherwise go to IGNORE.
- ADDR: shifts in 8 bits into the pointer. At bit 0, go to WDATA if R/W = 0, otherwise RDATA.
- WDATA: shifts in a byte. At bit 0, commit it if pointer < NUM_REGS and RO_MASK[pointer] = 0. Otherwise discard it. Then advance the pointer.
- RDATA: the shift-out register loads on the falling edge that follows the bit-0 rising edge of the previous byte. It loads ext_i byte for RO registers, the regfile byte for RW registers, and 8'h00 when pointer >= NUM_REGS. Pointer advances after each byte.
- Pointer advance: with SEQ_EN = 1, pointer becomes pointer+1, wrapping NUM_REGS-1 -> 0. An out-of-range pointer stays out of range. With SEQ_EN = 0, the pointer holds.
- IGNORE: no writes, miso_o = 0, miso_oe_o = 0 until csn_i rises.
- csn_i high asynchronously clears the frame logic: state = OPCODE, bit counter = 7, miso_o = 0, miso_oe_o = 0. A partially received byte is discarded. Register file, wr_* outputs and regs_o are unaffected.
- rst clears the frame logic as above, loads REG_INIT into the register file, and clears wr_stb_o, wr_addr_o and wr_data_o to 0. It requires sclk_i edges to take effect.
- RO registers read as REG_INIT in regs_o; their contents never change.

## Timing

- Reset values: miso_o = 0, miso_oe_o = 0, wr_stb_o = 0, wr_addr_o = 0, wr_data_o = 0, regs_o = REG_INIT.
- MOSI is sampled on the rising edge. MISO and miso_oe_o change only on the falling edge or on csn_i rising.
- First read bit (bit 7) is valid on the falling edge after the address byte's bit-0 rising edge. It is therefore stable before the first rising edge of the data byte.
- miso_oe_o rises with that first bit and stays high across consecutive read bytes. It falls on csn_i rising.
- Write commit is on the bit-0 rising edge of the data byte. regs_o updates on that edge. wr_stb_o is high from that edge to the next rising edge, with wr_addr_o/wr_data_o valid and held until the next commit.
- Reading a register written earlier in the same session returns the new value, provided the write frame ended before the read byte's load edge.
- Simultaneous rst and csn_i low: rst wins on that edge.

## Test plan

- Write 0x40, 0x05, 0xA5 -> wr_stb_o pulses once with addr 0x05 and data 0xA5; regs_o byte 5 = 0xA5; miso_oe_o stays 0.
- Read 0x41, 0x05 then 2 bytes (SEQ_EN=1, regs 5/6 = 0xA5/0x3C) -> MISO returns 0xA5 then 0x3C; miso_oe_o is high for 16 bits.
- Sequential write from address 0x15 (NUM_REGS=22) of 0x11, 0x22 -> reg 21 = 0x11, then wrap to reg 0 = 0x22.
- Opcode 0x42 followed by any bytes -> no wr_stb_o, miso_o = 0 throughout; the next valid frame works normally.
- RO_MASK bit 9 set with ext_i byte 9 = 0x5A: write 0xFF to 0x09 -> ignored; a read of 0x09 returns 0x5A; a read of 0x30 returns 0x00.
- csn_i raised after 4 bits of a write data byte -> no commit; rst mid-frame -> regs_o = REG_INIT and all outputs = 0.

Source files
------------

// File: rtl/spi_regfile_target.sv
// spi_regfile_target: SPI mode-0 register-file target with opcode/address framing and sequential access
module spi_regfile_target #(
    parameter int                    NUM_REGS   = 22,
    parameter logic [6:0]            DEV_OPCODE = 7'h20,
    parameter bit                    SEQ_EN     = 1'b1,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
    parameter logic [NUM_REGS*8-1:0] REG_INIT   = '0
) (
    input  logic                    sclk_i,
    input  logic                    rst,
    input  logic                    csn_i,
    input  logic                    mosi_i,
    output logic                    miso_o,
    output logic                    miso_oe_o,
    input  logic [NUM_REGS*8-1:0]   ext_i,
    output logic [NUM_REGS*8-1:0]   regs_o,
    output logic                    wr_stb_o,
    output logic [7:0]              wr_addr_o,
    output logic [7:0]              wr_data_o
);
    typedef enum logic [2:0] {OPCODE, ADDR, WDATA, RDATA, IGNORE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            bit_q, bit_d;
    logic [6:0]            sh_q, sh_d;
    logic [7:0]            ptr_q, ptr_d, ptr_nxt, byte_w, rd_byte;
    logic                  rw_q, rw_d, hit, ro_hit, commit;
    logic [7:0]            tx_q, tx_d;
    logic                  oe_q, oe_d;
    logic [NUM_REGS*8-1:0] regs_q, regs_d;
    logic                  wr_stb_q, wr_stb_d;
    logic [7:0]            wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;

    always_comb begin
        hit = 1'b0;
        ro_hit = 1'b0;
        rd_byte = 8'h00;
        for (int n = 0; n < NUM_REGS; n++)
            if (ptr_q == 8'(n)) begin
                hit = 1'b1;
                ro_hit = RO_MASK[n];
                rd_byte = RO_MASK[n] ? ext_i[8*n +: 8] : regs_q[8*n +: 8];
            end
        ptr_nxt = (!SEQ_EN || !hit) ? ptr_q : (ptr_q == 8'(NUM_REGS - 1)) ? 8'h00 : ptr_q + 8'd1;
    end

    always_comb begin
        byte_w = {sh_q, mosi_i};
        sh_d = byte_w[6:0];
        bit_d = bit_q - 3'd1;
        state_d = state_q;
        ptr_d = ptr_q;
        rw_d = rw_q;
        commit = 1'b0;
        if (bit_q == 3'd0)
            case (state_q)
                OPCODE: begin
                    state_d = (byte_w[7:1] == DEV_OPCODE) ? ADDR : IGNORE;
                    rw_d = byte_w[0];
                end
                ADDR: begin
                    ptr_d = byte_w;
                    state_d = rw_q ? RDATA : WDATA;
                end
                WDATA: begin
                    commit = hit && !ro_hit;
                    ptr_d = ptr_nxt;
                end
                RDATA: ptr_d = ptr_nxt;
                default: ;
            endcase
        // bit_q == 7 on the falling edge right after a byte boundary: load the next read byte
        tx_d = (rst || state_q != RDATA) ? 8'h00 : (bit_q == 3'd7) ? rd_byte : {tx_q[6:0], 1'b0};
        oe_d = !rst && state_q == RDATA;
        wr_stb_d = commit;
        wr_addr_d = commit ? ptr_q : wr_addr_q;
        wr_data_d = commit ? byte_w : wr_data_q;
        regs_d = regs_q;
        for (int n = 0; n < NUM_REGS; n++)
            if (commit && ptr_q == 8'(n)) regs_d[8*n +: 8] = byte_w;
        if (rst) begin
            state_d = OPCODE;
            bit_d = 3'd7;
            sh_d = '0;
            ptr_d = '0;
            rw_d = 1'b0;
            regs_d = REG_INIT;
            wr_stb_d = 1'b0;
            wr_addr_d = '0;
            wr_data_d = '0;
        end
    end

    always_ff @(posedge sclk_i or posedge csn_i) begin
        if (csn_i) begin
            state_q <= OPCODE;
            bit_q <= 3'd7;
            sh_q <= '0;
            ptr_q <= '0;
            rw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q <= bit_d;
            sh_q <= sh_d;
            ptr_q <= ptr_d;
            rw_q <= rw_d;
        end
    end

    always_ff @(negedge sclk_i or posedge csn_i) begin
        if (csn_i) begin
            tx_q <= '0;
            oe_q <= 1'b0;
        end else begin
            tx_q <= tx_d;
            oe_q <= oe_d;
        end
    end

    always_ff @(posedge sclk_i) begin
        regs_q <= regs_d;
        wr_stb_q <= wr_stb_d;
        wr_addr_q <= wr_addr_d;
        wr_data_q <= wr_data_d;
    end

    assign miso_o = tx_q[7];
    assign miso_oe_o = oe_q;
    assign regs_o = regs_q;
    assign wr_stb_o = wr_stb_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
endmodule
